async_handshake_top: RTL and testbench
======================================

// Module: async_handshake_top
// PURPOSE
//  Master/slave pair that exchanges one DATA_W-bit word over a 4-phase req/ack handshake.
//  Each side re-synchronises the other side's handshake signal, so both sides behave as if they were in independent clock domains.
//  One start pulse runs one transfer:
//   - write (rw_in=0): master -> slave.
//   - read  (rw_in=1): slave -> master.
//  This is the top-level wrapper of the async-protocol demo.
// PARAMETERS
//  DATA_W       4  width of the data words and of the internal data bus
//  SYNC_STAGES  2  flops in each req/ack synchroniser (must be >= 2)
// PORTS
//  clk          in   1       single clock for master, slave and synchronisers
//  rst          in   1       asynchronous, active-low reset (0 = reset asserted)
//  start        in   1       a 0->1 edge starts one transfer
//  rw_in        in   1       0 = write to slave, 1 = read from slave; sampled at the start edge
//  m_data_in    in   DATA_W  master write word; sampled at the start edge
//  s_data_in    in   DATA_W  slave read word; sampled when the slave accepts a read req
//  m_rcvd_data  out  DATA_W  last word the master received (read)
//  s_rcvd_data  out  DATA_W  last word the slave received (write)
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - all flops clear; m_rcvd_data = 0, s_rcvd_data = 0.
//   - req = ack = 0, bus = 0, start_q = 0; both FSMs go to IDLE.
//  Start detection:
//   - start_q registers start; start_edge = start & ~start_q.
//   - If start is already 1 in the first cycle after reset, that counts as an edge.
//   - Holding start high gives exactly one transfer.
//   - An edge while the master is not IDLE is ignored (dropped, not queued).
//  Master FSM, states IDLE -> REQ -> REL -> IDLE:
//   - IDLE: on start_edge, latch rw_in and m_data_in onto the bus; set req=1; go to REQ.
//   - REQ: wait for ack_s=1. Then set req=0 and go to REL.
//     On a read, in that same cycle, m_rcvd_data <= bus.
//   - REL: wait for ack_s=0, then go to IDLE.
//  Slave FSM, states IDLE -> ACK -> IDLE:
//   - IDLE, on req_s=1:
//     - write: s_rcvd_data <= bus.
//     - read: slave drives s_data_in onto the bus.
//     - in both cases set ack=1 and go to ACK.
//   - ACK: on req_s=0, set ack=0 and go to IDLE.
//  Synchronisation:
//   - req_s and ack_s are the SYNC_STAGES-flop synchronised copies of req and ack.
//  Bus rules:
//   - The bus carries rw and data.
//   - rw and write data stay stable from req rise to ack fall.
//   - Read data stays stable from ack rise to req fall.
//  Timing, SYNC_STAGES=2, E0 = the edge that samples start_edge:
//   - req=1 at E0.
//   - Slave acts at E3 (s_rcvd_data valid, ack=1).
//   - Master acts at E6 (m_rcvd_data valid on a read, req=0).
//   - ack=0 at E9.
//   - Master is IDLE at E12; the next start edge is accepted from E12.
//  Outputs hold their value until the next transfer of the same direction.
//  A read never alters s_rcvd_data; a write never alters m_rcvd_data.
//  Reset during a transfer aborts it; the partial word is never delivered.
// STRUCTURE
//  Shared package async_hs_pkg holds:
//   - DATA_W and SYNC_STAGES defaults;
//   - the master state enum (M_IDLE, M_REQ, M_REL);
//   - the slave state enum (S_IDLE, S_ACK);
//   - the constants RW_WRITE=0 and RW_READ=1.
//  Sub-module hs_sync (parameter SYNC_STAGES, 1-bit) is instantiated twice: once for req, once for ack.
//  The master FSM, slave FSM and data registers live in the top file.
// TESTING
//  1. Write: release rst, start=1, rw_in=0, m_data_in=12.
//     -> s_rcvd_data=12 at E3; m_rcvd_data stays 0; req and ack back at 0 by E12.
//  2. Read: release rst, start=1, rw_in=1, s_data_in=13.
//     -> m_rcvd_data=13 at E6; s_rcvd_data stays 0.
//  3. Start held high for 5 cycles, then low.
//     -> exactly one transfer; req rises exactly once.
//  4. Write 5, then read 9 after the master is back in IDLE.
//     -> s_rcvd_data=5 and m_rcvd_data=9; each output keeps its value.
//  5. A second start edge at E4 during a transfer, with m_data_in changed to 3.
//     -> ignored; s_rcvd_data remains the original value.
//  6. rst=0 at E4 of a write of 7.
//     -> both outputs 0 and FSMs IDLE immediately; a new write of 7 completes normally.

Source files
------------

// File: rtl/async_hs_pkg.sv
// Shared types and defaults for the req/ack handshake demo.
package async_hs_pkg;

  localparam int unsigned DATA_W_DEFAULT      = 4;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [1:0] {
    M_IDLE,
    M_REQ,
    M_REL
  } m_state_e;

  typedef enum logic {
    S_IDLE,
    S_ACK
  } s_state_e;

endpackage

// File: rtl/async_handshake_top_hs_sync.sv
// Multi-flop synchroniser for a single handshake level.
module hs_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/async_handshake_top.sv
// Master/slave pair moving one word over a synchronised 4-phase req/ack handshake.
module async_handshake_top
  import async_hs_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw_in,
  input  logic [DATA_W-1:0] m_data_in,
  input  logic [DATA_W-1:0] s_data_in,
  output logic [DATA_W-1:0] m_rcvd_data,
  output logic [DATA_W-1:0] s_rcvd_data
);

  m_state_e          m_state_q, m_state_d;
  s_state_e          s_state_q, s_state_d;
  logic              start_q, start_d;
  logic              req_q, req_d;
  logic              ack_q, ack_d;
  logic              bus_rw_q, bus_rw_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic [DATA_W-1:0] m_rcvd_q, m_rcvd_d;
  logic [DATA_W-1:0] s_rcvd_q, s_rcvd_d;
  logic              req_s, ack_s;
  logic              start_edge;

  hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (req_q),
    .q     (req_s)
  );

  hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (ack_q),
    .q     (ack_s)
  );

  assign start_edge = start & ~start_q;

  // Both sides share one bus register; the slave only writes data while the master waits in REQ.
  always_comb begin
    m_state_d  = m_state_q;
    s_state_d  = s_state_q;
    start_d    = start;
    req_d      = req_q;
    ack_d      = ack_q;
    bus_rw_d   = bus_rw_q;
    bus_data_d = bus_data_q;
    m_rcvd_d   = m_rcvd_q;
    s_rcvd_d   = s_rcvd_q;

    case (m_state_q)
      M_IDLE: begin
        if (start_edge) begin
          bus_rw_d   = rw_in;
          bus_data_d = m_data_in;
          req_d      = 1'b1;
          m_state_d  = M_REQ;
        end
      end
      M_REQ: begin
        if (ack_s) begin
          if (bus_rw_q == RW_READ) m_rcvd_d = bus_data_q;
          req_d     = 1'b0;
          m_state_d = M_REL;
        end
      end
      M_REL: begin
        if (!ack_s) m_state_d = M_IDLE;
      end
      default: m_state_d = M_IDLE;
    endcase

    case (s_state_q)
      S_IDLE: begin
        if (req_s) begin
          if (bus_rw_q == RW_WRITE) s_rcvd_d   = bus_data_q;
          else                      bus_data_d = s_data_in;
          ack_d     = 1'b1;
          s_state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!req_s) begin
          ack_d     = 1'b0;
          s_state_d = S_IDLE;
        end
      end
      default: s_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state_q  <= M_IDLE;
      s_state_q  <= S_IDLE;
      start_q    <= 1'b0;
      req_q      <= 1'b0;
      ack_q      <= 1'b0;
      bus_rw_q   <= 1'b0;
      bus_data_q <= '0;
      m_rcvd_q   <= '0;
      s_rcvd_q   <= '0;
    end else begin
      m_state_q  <= m_state_d;
      s_state_q  <= s_state_d;
      start_q    <= start_d;
      req_q      <= req_d;
      ack_q      <= ack_d;
      bus_rw_q   <= bus_rw_d;
      bus_data_q <= bus_data_d;
      m_rcvd_q   <= m_rcvd_d;
      s_rcvd_q   <= s_rcvd_d;
    end
  end

  assign m_rcvd_data = m_rcvd_q;
  assign s_rcvd_data = s_rcvd_q;

endmodule

// File: tb/tb_async_handshake_top.sv
// Bench for async_handshake_top: vector table, timed corner sequences and random transfers.
module tb_async_handshake_top;
  import async_hs_pkg::*;

  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          rw_in = 1'b0;
  logic [DW-1:0] m_data_in = '0;
  logic [DW-1:0] s_data_in = '0;
  logic [DW-1:0] m_rcvd_data;
  logic [DW-1:0] s_rcvd_data;

  int passed = 0;
  int total  = 0;
  int req_rises = 0;
  int m_model = 0;
  int s_model = 0;

  async_handshake_top #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rw_in       (rw_in),
    .m_data_in   (m_data_in),
    .s_data_in   (s_data_in),
    .m_rcvd_data (m_rcvd_data),
    .s_rcvd_data (s_rcvd_data)
  );

  always #5 clk = ~clk;

  always @(posedge dut.req_q) req_rises = req_rises + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act == exp) passed = passed + 1;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " m_rcvd"}, int'(m_rcvd_data), m_model);
    check({tag, " s_rcvd"}, int'(s_rcvd_data), s_model);
  endtask

  function automatic int m_idle();
    return (dut.m_state_q == M_IDLE) ? 1 : 0;
  endfunction

  // Ends with rst released at a negedge; the next posedge is the first after reset.
  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    m_model = 0;
    s_model = 0;
    check_outputs("reset");
    check("reset req", int'(dut.req_q), 0);
    check("reset ack", int'(dut.ack_q), 0);
    check("reset m_idle", m_idle(), 1);
    rst = 1'b1;
  endtask

  // Caller is at a negedge; one-cycle start pulse, returns #1 after E13.
  task automatic run_xfer(input logic rw, input int md, input int sd,
                          input bit timed, input bit inject);
    rw_in = rw;
    m_data_in = DW'(md);
    s_data_in = DW'(sd);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (timed) check("E0 req", int'(dut.req_q), 1);
    for (int e = 1; e <= 13; e++) begin
      @(posedge clk); #1;
      if (inject && e == 4) begin
        start = 1'b1;
        m_data_in = 4'd3;
      end
      if (timed) begin
        case (e)
          2: begin
            check("E2 ack", int'(dut.ack_q), 0);
            check("E2 s_rcvd", int'(s_rcvd_data), s_model);
          end
          3: begin
            check("E3 ack", int'(dut.ack_q), 1);
            check("E3 s_rcvd", int'(s_rcvd_data), (rw == RW_WRITE) ? md : s_model);
          end
          5: begin
            check("E5 req", int'(dut.req_q), 1);
            check("E5 m_rcvd", int'(m_rcvd_data), m_model);
          end
          6: begin
            check("E6 req", int'(dut.req_q), 0);
            check("E6 m_rcvd", int'(m_rcvd_data), (rw == RW_READ) ? sd : m_model);
          end
          8: check("E8 ack", int'(dut.ack_q), 1);
          9: check("E9 ack", int'(dut.ack_q), 0);
          11: check("E11 m_idle", m_idle(), 0);
          12: check("E12 m_idle", m_idle(), 1);
          default: ;
        endcase
      end
    end
    start = 1'b0;
    if (rw == RW_WRITE) s_model = md;
    else                m_model = sd;
  endtask

  typedef struct {
    logic rw;
    int   md;
    int   sd;
    int   exp_m;
    int   exp_s;
  } vec_t;

  vec_t vecs[6];
  int   rises0;

  initial begin
    vecs[0] = '{RW_WRITE, 5,  2,  0,  5};
    vecs[1] = '{RW_READ,  1,  9,  9,  5};
    vecs[2] = '{RW_WRITE, 0,  7,  9,  0};
    vecs[3] = '{RW_READ,  4,  15, 15, 0};
    vecs[4] = '{RW_WRITE, 15, 6,  15, 15};
    vecs[5] = '{RW_READ,  8,  0,  0,  15};

    // 1: write 12 straight out of reset, with edge timing
    do_reset();
    run_xfer(RW_WRITE, 12, 0, 1'b1, 1'b0);
    check_outputs("t1");
    check("t1 m_rcvd zero", int'(m_rcvd_data), 0);
    check("t1 req", int'(dut.req_q), 0);
    check("t1 ack", int'(dut.ack_q), 0);

    // 2: read 13 straight out of reset
    @(negedge clk);
    do_reset();
    run_xfer(RW_READ, 5, 13, 1'b1, 1'b0);
    check("t2 m_rcvd", int'(m_rcvd_data), 13);
    check("t2 s_rcvd zero", int'(s_rcvd_data), 0);

    // 3: start held for 5 cycles gives one transfer
    @(negedge clk);
    do_reset();
    @(negedge clk);
    rises0 = req_rises;
    rw_in = RW_WRITE;
    m_data_in = 4'd6;
    start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    check("t3 req rises", req_rises - rises0, 1);
    s_model = 6;
    check_outputs("t3");

    // 4: table of back-to-back transfers from reset
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run_xfer(vecs[i].rw, vecs[i].md, vecs[i].sd, 1'b0, 1'b0);
      check($sformatf("vec%0d m_rcvd", i), int'(m_rcvd_data), vecs[i].exp_m);
      check($sformatf("vec%0d s_rcvd", i), int'(s_rcvd_data), vecs[i].exp_s);
    end

    // 5: second start edge at E4 is dropped
    @(negedge clk);
    rises0 = req_rises;
    run_xfer(RW_WRITE, 10, 0, 1'b0, 1'b1);
    repeat (15) @(negedge clk);
    check("t5 s_rcvd", int'(s_rcvd_data), 10);
    check("t5 req rises", req_rises - rises0, 1);

    // 6: asynchronous reset at E4 of a write of 7
    do_reset();
    @(negedge clk);
    rw_in = RW_WRITE;
    m_data_in = 4'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    m_model = 0;
    s_model = 0;
    check_outputs("t6 abort");
    check("t6 req", int'(dut.req_q), 0);
    check("t6 ack", int'(dut.ack_q), 0);
    check("t6 m_idle", m_idle(), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_xfer(RW_WRITE, 7, 0, 1'b0, 1'b0);
    check("t6 s_rcvd", int'(s_rcvd_data), 7);

    // random transfers against the word-level model
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = int'($urandom_range(1, 4));
      repeat (gap) @(negedge clk);
      run_xfer(logic'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), 1'b0, 1'b0);
      check_outputs($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
